vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001: Parameter DATA_W, default 12, pixel word width as 4-bit red, green, blue (red in [11:8], blue in [3:0]).
REQ-002: Parameter ADDR_W, default 15, frame-buffer address width for a 160x120 buffer.
REQ-003: Parameter FIFO_DEPTH, default 4, write-queue entries; SHALL be a power of two, 2 or more.
REQ-004: clk  input  1  pixel clock, the divided clock that drives the h/v counters.
REQ-005: rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-006: video_on  input  1  display active-region flag from the sync block.
REQ-007: x_loc, y_loc  input  10 each  current pixel coordinates from the sync block.
REQ-008: wr_valid  input  1  drawing-engine write request.
REQ-009: wr_addr  input  ADDR_W  drawing-engine write address.
REQ-010: wr_data  input  DATA_W  drawing-engine write data.
REQ-011: wr_ready  output  1  write queue can accept an entry.
REQ-012: mem_addr  output  ADDR_W  registered RAM address.
REQ-013: mem_we  output  1  registered RAM write enable.
REQ-014: mem_wdata  output  DATA_W  registered RAM write data.
REQ-015: mem_rdata  input  DATA_W  single-port synchronous RAM read data, valid 1 cycle after mem_addr.
REQ-016: disp_data  output  DATA_W  pixel word to the pixel generator.
REQ-017: disp_valid  output  1  disp_data corresponds to an active pixel.

Function
REQ-018: A write is accepted on a cycle where wr_valid and wr_ready are both 1; accepted entries are queued in FIFO order.
REQ-019: wr_ready SHALL be the registered value of "FIFO not full" and SHALL NOT depend combinationally on the pop in the same cycle.
REQ-020: The FSM SHALL have three states, IDLE, SCAN and DRAIN, re-evaluated every cycle from video_on and FIFO occupancy.
REQ-021: If video_on=1, the next state SHALL be SCAN; if video_on=0 and the FIFO is non-empty, it SHALL be DRAIN; otherwise it SHALL be IDLE.
REQ-022: Display reads have absolute priority; no write is issued on any cycle where video_on=1.
REQ-023: In SCAN, on the next edge: mem_addr <= (y_loc>>2)*160 + (x_loc>>2), computed as shifts and adds with no multiplier; mem_we <= 0.
REQ-024: In DRAIN, on the next edge: mem_addr <= head address, mem_wdata <= head data, mem_we <= 1, and one entry is popped, so one write retires per cycle.
REQ-025: In IDLE, mem_we <= 0 and mem_addr holds its value.
REQ-026: Push and pop in the same cycle leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027: disp_valid SHALL be video_on delayed by exactly 3 cycles.
REQ-028: disp_data <= mem_rdata when the 2-cycle-delayed video_on is 1, else 0; total latency from x_loc/y_loc to disp_data is 3 cycles.
REQ-029: If video_on rises while the FIFO is non-empty, draining SHALL stop immediately and resume on the next blanking cycle with no entry lost or duplicated.
REQ-030: Writes to an address at or above 19200 SHALL be forwarded unmodified; range checking belongs to the writer.

Reset
REQ-031: While rst_n=0 at a clk edge: FSM <= IDLE, FIFO emptied, wr_ready <= 0, mem_we <= 0, mem_addr <= 0, mem_wdata <= 0, disp_data <= 0, disp_valid <= 0, and the delay pipeline is cleared.
REQ-032: Reset asserted mid-drain SHALL discard all queued entries; mem_we SHALL be 0 from the first edge with rst_n=0.
REQ-033: wr_ready SHALL become 1 on the first edge after rst_n returns to 1.

Configuration
REQ-034: Macro VRAM_ARB_STATS_EN, when defined, adds output wr_commit_cnt [15:0], incremented once per retired write and wrapping at 0xFFFF to 0.
REQ-035: It also adds output wr_stall, high on any cycle with wr_valid=1 and wr_ready=0.
REQ-036: Both outputs reset to 0.
REQ-037: Without VRAM_ARB_STATS_EN those ports and their logic SHALL be absent and all other behaviour is identical.

Verification
REQ-038: video_on=1, x_loc=8, y_loc=4, mem_rdata returns 0xABC -> mem_addr=162 one cycle later; disp_data=0xABC and disp_valid=1 three cycles later.
REQ-039: video_on=1 held, 3 writes pushed -> mem_we stays 0; when video_on falls, writes appear on mem_addr/mem_wdata on 3 consecutive cycles in push order.
REQ-040: 4 pushes with video_on=1 -> wr_ready=0 after the 4th push; a 5th wr_valid is not accepted; wr_stall=1 when stats are enabled.
REQ-041: video_on rises after 2 of 4 queued writes retire -> a drain pause with no write issued; the remaining 2 retire on the next blanking cycles; wr_commit_cnt=4.
REQ-042: rst_n=0 asserted mid-drain with 3 entries queued -> mem_we=0 on the next edge; after release, wr_ready=1 and no further writes retire.
REQ-043: Simultaneous push and pop with 1 entry queued during blanking -> occupancy stays 1 and data order is preserved.

Source files
------------

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous frame-buffer RAM between the display scan
// (reads) and a drawing engine (writes). Display reads always win: while
// video_on is high the RAM is addressed from the pixel coordinates. Writes are
// parked in a small FIFO and retired one per cycle during blanking.
//
// Optional feature macro: VRAM_ARB_STATS_EN adds wr_commit_cnt and wr_stall.
//
// Handshake (write port): a write is accepted on every clk edge where
// wr_valid and wr_ready are both 1. The writer holds wr_addr/wr_data stable
// while wr_valid is high and wr_ready is low. wr_ready is a registered
// "FIFO not full" and never depends combinationally on this cycle's pop.
//
// Ports
//   clk, rst_n          pixel clock, synchronous active-low reset
//   video_on            active display region flag
//   x_loc, y_loc        current pixel coordinates (10 bits each)
//   wr_valid/wr_ready   write request handshake
//   wr_addr, wr_data    write payload
//   mem_addr/we/wdata   registered RAM controls
//   mem_rdata           RAM read data, valid one cycle after mem_addr
//   disp_data/valid     pixel word to the pixel generator (3-cycle latency)
//   wr_commit_cnt       (stats) retired write count, wraps at 16 bits
//   wr_stall            (stats) wr_valid high while wr_ready low
//   dbg_state           current arbiter state (IDLE/SCAN/DRAIN)
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              video_on,
  input  logic [9:0]        x_loc,
  input  logic [9:0]        y_loc,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]       wr_commit_cnt,
  output logic              wr_stall,
`endif
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ready_q, wr_ready_d;
  logic              push, pop;
  logic              fifo_not_empty;

  assign push           = wr_valid & wr_ready_q;
  assign fifo_not_empty = (count_q != '0);

  // Pop only when the arbiter commits to a write on the next edge; an entry
  // pushed this cycle is not visible to the arbiter until the next cycle.
  assign pop = (state_d == DRAIN);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Ready reflects occupancy after this edge, so it is a clean register.
    wr_ready_d = (count_d != CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready = wr_ready_q;

  // ---------------------------------------------------------------------------
  // Arbiter FSM: state_d names what the RAM port does on the coming edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = IDLE;
    if (video_on) begin
      state_d = SCAN;
    end else if (fifo_not_empty) begin
      state_d = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Scan address: (y/4)*160 + x/4, with 160 = 128 + 32.
  // ---------------------------------------------------------------------------
  logic [16:0] row_ext, col_ext, scan_lin;
  logic [ADDR_W-1:0] scan_addr;

  assign row_ext   = {7'd0, (y_loc >> 2)};
  assign col_ext   = {7'd0, (x_loc >> 2)};
  assign scan_lin  = (row_ext << 7) + (row_ext << 5) + col_ext;
  assign scan_addr = ADDR_W'(scan_lin);

  // ---------------------------------------------------------------------------
  // RAM control registers
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      case (state_d)
        SCAN: begin
          mem_addr_q <= scan_addr;
          mem_we_q   <= 1'b0;
        end
        DRAIN: begin
          // Addresses are forwarded as-is; bounds are the writer's concern.
          mem_addr_q  <= fifo_addr_q[rd_ptr_q];
          mem_wdata_q <= fifo_data_q[rd_ptr_q];
          mem_we_q    <= 1'b1;
        end
        default: begin
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

  // ---------------------------------------------------------------------------
  // Display pipeline: address reg (1) + RAM read (1) + output reg (1).
  // video_on is delayed alongside so disp_valid lines up with disp_data.
  // ---------------------------------------------------------------------------
  logic              vid_d1_q, vid_d2_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vid_d1_q     <= 1'b0;
      vid_d2_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      vid_d1_q     <= video_on;
      vid_d2_q     <= vid_d1_q;
      disp_valid_q <= vid_d2_q;
      disp_data_q  <= vid_d2_q ? mem_rdata : '0;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

`ifdef VRAM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [15:0] commit_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_cnt_q <= '0;
    end else if (pop) begin
      commit_cnt_q <= commit_cnt_q + 16'd1;
    end
  end

  assign wr_commit_cnt = commit_cnt_q;
  assign wr_stall      = wr_valid & ~wr_ready_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Drives vram_arbiter with directed scenarios followed by randomized traffic.
// A reference model (queue of pending writes plus a shadow frame buffer)
// predicts retired writes and displayed pixels; a monitor on the falling edge
// pops the expected queues whenever the DUT presents a write or a pixel.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int DW    = 12;
  localparam int AW    = 15;
  localparam int DEPTH = 4;
  localparam int MEM_N = 1 << AW;
  localparam int WR_W  = 32 + AW + DW;
  localparam int PX_W  = 32 + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          video_on;
  logic [9:0]    x_loc, y_loc;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic [1:0]    dbg_state;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   wr_commit_cnt;
  logic          wr_stall;
`endif

  vram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .video_on   (video_on),
    .x_loc      (x_loc),
    .y_loc      (y_loc),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
`ifdef VRAM_ARB_STATS_EN
    .wr_commit_cnt (wr_commit_cnt),
    .wr_stall      (wr_stall),
`endif
    .dbg_state  (dbg_state)
  );

  // single-port synchronous RAM
  logic [DW-1:0] ram [MEM_N];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------------------------------------------------------------------
  // scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           pend[$];
  logic [DW-1:0] mem_m [MEM_N];
  logic [WR_W-1:0] exp_wr_q[$];
  logic [PX_W-1:0] exp_pix_q[$];
  int   cyc      = 0;
  logic ready_m  = 1'b0;
  int   commit_m = 0;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 37 + 5) ^ (a >> 4));
  endfunction

  always @(posedge clk) begin
    wr_t w;
    int  ad;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      exp_wr_q.delete();
      exp_pix_q.delete();
      ready_m  = 1'b0;
      commit_m = 0;
    end else begin
      // blanking retires the oldest pending write, visible after this edge
      if (!video_on && pend.size() > 0) begin
        w = pend.pop_front();
        mem_m[w.a] = w.d;
        exp_wr_q.push_back({cyc[31:0], w.a, w.d});
        commit_m = (commit_m + 1) % 65536;
      end
      if (video_on) begin
        ad = ((int'(y_loc) / 4) * 160 + int'(x_loc) / 4) % MEM_N;
        exp_pix_q.push_back({32'(cyc + 2), mem_m[ad]});
      end
      if (wr_valid && ready_m) pend.push_back({wr_addr, wr_data});
      ready_m = (pend.size() < DEPTH);
    end
  end

  // ---------------------------------------------------------------------------
  // monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [WR_W-1:0] e;
    logic [PX_W-1:0] p;
    if (cyc > 0) begin
      check("wr_ready", wr_ready, ready_m);
`ifdef VRAM_ARB_STATS_EN
      check("wr_commit_cnt", wr_commit_cnt, commit_m);
      check("wr_stall", wr_stall, wr_valid & ~ready_m);
`endif
      if (mem_we === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_unexpected", mem_we, 1'b0);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", mem_addr, e[AW+DW-1:DW]);
          check("wr_data", mem_wdata, e[DW-1:0]);
          check("wr_cycle", cyc, e[WR_W-1:AW+DW]);
        end
      end else if (exp_wr_q.size() > 0 && int'(exp_wr_q[0][WR_W-1:AW+DW]) <= cyc) begin
        check("wr_missing", mem_we, 1'b1);
        void'(exp_wr_q.pop_front());
      end

      if (disp_valid === 1'b1) begin
        if (exp_pix_q.size() == 0) begin
          check("pix_unexpected", disp_valid, 1'b0);
        end else begin
          p = exp_pix_q.pop_front();
          check("pix_data", disp_data, p[DW-1:0]);
          check("pix_cycle", cyc, p[PX_W-1:DW]);
        end
      end else begin
        check("pix_idle_data", disp_data, '0);
        if (exp_pix_q.size() > 0 && int'(exp_pix_q[0][PX_W-1:DW]) <= cyc) begin
          check("pix_missing", disp_valid, 1'b1);
          void'(exp_pix_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // driver: one call = one rising edge with the given inputs
  // ---------------------------------------------------------------------------
  task automatic step(input logic vo, input logic [9:0] x, input logic [9:0] y,
                      input logic wv, input logic [AW-1:0] a, input logic [DW-1:0] d);
    video_on = vo;
    x_loc    = x;
    y_loc    = y;
    wr_valid = wv;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic          vo, wv;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    int            run;

    for (int i = 0; i < MEM_N; i++) begin
      ram[i]   = init_val(i);
      mem_m[i] = init_val(i);
    end
    ram[162]   = 12'hABC;
    mem_m[162] = 12'hABC;

    // reset state
    rst_n = 1'b0;
    idle(3);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_disp_data", disp_data, '0);
    check("rst_disp_valid", disp_valid, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_rst", wr_ready, 1'b1);

    // scan address and 3-cycle display latency
    step(1'b1, 10'd8, 10'd4, 1'b0, '0, '0);
    check("scan_addr_162", mem_addr, 162);
    idle(2);
    check("disp_abc", disp_data, 12'hABC);
    check("disp_valid_abc", disp_valid, 1'b1);
    idle(2);

    // writes held off during active video, then drained in order
    step(1'b1, 10'd100, 10'd50, 1'b1, 15'd10, 12'h111);
    step(1'b1, 10'd104, 10'd50, 1'b1, 15'd11, 12'h222);
    step(1'b1, 10'd108, 10'd50, 1'b1, 15'd12, 12'h333);
    step(1'b1, 10'd112, 10'd50, 1'b0, '0, '0);
    check("no_we_video", mem_we, 1'b0);
    idle(5);

    // fill the FIFO, 5th request refused
    for (int i = 0; i < 4; i++)
      step(1'b1, 10'(i * 4), 10'd8, 1'b1, 15'(20 + i), 12'(12'h400 + i));
    check("full_not_ready", wr_ready, 1'b0);
    step(1'b1, 10'd20, 10'd8, 1'b1, 15'd99, 12'hBAD);
`ifdef VRAM_ARB_STATS_EN
    check("stall_when_full", wr_stall, 1'b1);
`endif

    // drain interrupted by video, resumed on blanking
    idle(2);
    step(1'b1, 10'd40, 10'd40, 1'b1, 15'd99, 12'hBAD);
    check("drain_paused", mem_we, 1'b0);
    step(1'b1, 10'd44, 10'd40, 1'b0, '0, '0);
    idle(6);

    // reset mid-drain discards queued entries
    step(1'b1, 10'd0, 10'd0, 1'b1, 15'd30, 12'h0A1);
    step(1'b1, 10'd4, 10'd0, 1'b1, 15'd31, 12'h0A2);
    step(1'b1, 10'd8, 10'd0, 1'b1, 15'd32, 12'h0A3);
    step(1'b0, 10'd0, 10'd0, 1'b0, '0, '0);
    rst_n = 1'b0;
    idle(1);
    check("rst_mid_drain_we", mem_we, 1'b0);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_rst2", wr_ready, 1'b1);
    idle(4);

    // push and pop on the same edge keep order
    step(1'b1, 10'd0, 10'd0, 1'b1, 15'd40, 12'h0B1);
    step(1'b0, 10'd0, 10'd0, 1'b1, 15'd41, 12'h0B2);
    step(1'b0, 10'd0, 10'd0, 1'b1, 15'd42, 12'h0B3);
    idle(3);

    // randomized traffic with bursty video and held write payloads
    vo  = 1'b0;
    run = 0;
    pa  = AW'($urandom_range(0, 19199));
    pd  = DW'($urandom);
    wv  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        vo  = ~vo;
        run = vo ? $urandom_range(4, 40) : $urandom_range(1, 12);
      end
      run--;
      if (!wv) wv = ($urandom_range(0, 3) != 0);
      if (wv && ready_m) begin
        step(vo, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), wv, pa, pd);
        wv = 1'b0;
        pa = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(19200, MEM_N - 1))
                                         : AW'($urandom_range(0, 19199));
        pd = DW'($urandom);
      end else begin
        step(vo, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), wv, pa, pd);
      end
    end

    idle(12);
    check("wr_queue_empty", exp_wr_q.size(), 0);
    check("pix_queue_empty", exp_pix_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
